alu_share_arbiter: RTL

Shares one multi-cycle ALU (XOR, ADD, SUB, CMP) between two requesters using round-robin arbitration.
- Each requester presents op and operands with a level req.
- The block grants one requester, latches its operands, runs the op for EXEC_CYCLES cycles, then pulses done with result and requester ID.
- Sits between the sessional ALU datapath cells (mux/add/sub/compare/xor) and their users.

---
 rtl/alu_share_arbiter_if.sv | 32 +++
 rtl/alu_share_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Requester/result bundle shared by two ALU clients and the alu_share_arbiter.
// master = requester side (testbench or user logic), slave = the arbiter.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [1:0]       op0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [1:0]       op1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] result;
  logic             flag;
  logic             ovf;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, result, flag, ovf
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output gnt0, gnt1, busy, done, done_id, result, flag, ovf
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one multi-cycle XOR/ADD/SUB/CMP ALU between two requesters.
// Optional signed-overflow output enabled by defining ALU_OVF_DETECT_EN.
module alu_share_arbiter #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus
);
  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q;
  logic             owner_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q;
  logic             flag_q;
  logic             id_q;

  logic             any_req;
  logic             pick;
  logic             latch_req;
  logic             finish_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_flag;

  // Alternate on a tie: the requester that did not win last time goes first.
  assign any_req   = bus.req0 | bus.req1;
  assign pick      = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign latch_req = (state_q == S_IDLE) && any_req;
  assign finish_op = (state_q == S_EXEC) && (cnt_q == CNT_LAST);

  // Datapath works only on the latched copy so requester inputs may move during EXEC.
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res  = '0;
    alu_flag = 1'b0;
    case (op_q)
      OP_XOR: alu_res = a_q ^ b_q;
      OP_ADD: begin
        alu_res  = sum[WIDTH-1:0];
        alu_flag = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res  = diff[WIDTH-1:0];
        alu_flag = diff[WIDTH];
      end
      OP_CMP: begin
        alu_res[0] = a_q < b_q;
        alu_res[1] = a_q == b_q;
        alu_res[2] = a_q > b_q;
        alu_flag   = a_q == b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_req) begin
        owner_q <= pick;
        last_q  <= pick;
        op_q    <= pick ? bus.op1 : bus.op0;
        a_q     <= pick ? bus.a1  : bus.a0;
        b_q     <= pick ? bus.b1  : bus.b0;
      end
      if (finish_op) begin
        result_q <= alu_res;
        flag_q   <= alu_flag;
        id_q     <= owner_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (any_req) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cnt_q == CNT_LAST) state_d = S_DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.gnt0 = 1'b0;
    bus.gnt1 = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      S_EXEC: begin
        bus.busy = 1'b1;
        bus.gnt0 = (cnt_q == '0) && !owner_q;
        bus.gnt1 = (cnt_q == '0) &&  owner_q;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.result  = result_q;
  assign bus.flag    = flag_q;
  assign bus.done_id = id_q;

`ifdef ALU_OVF_DETECT_EN
  logic ovf_q;
  logic alu_ovf;

  always_comb begin
    alu_ovf = 1'b0;
    if (op_q == OP_ADD)
      alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    else if (op_q == OP_SUB)
      alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf_q <= 1'b0;
    else if (finish_op) ovf_q <= alu_ovf;
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule
